// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: datapath width, ALU op codes, forwarding and result-select codes.
package riscv_pkg;
  localparam int XLEN = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // The younger producer in MEM takes priority over WB; x0 is never forwarded.
  function automatic logic [1:0] fwdSel(input logic regwriteM, input logic [4:0] rdM,
                                        input logic regwriteW, input logic [4:0] rdW,
                                        input logic [4:0] rs);
    if (regwriteM && (rdM == rs) && (rs != 5'd0))      return FWD_M;
    else if (regwriteW && (rdW == rs) && (rs != 5'd0)) return FWD_W;
    else                                                return FWD_RF;
  endfunction
endpackage

// File: rtl/execute_if.sv
// ID/EX bundle, writeback feedback, redirect and EX/MEM outputs of the execute stage.
interface execute_if;
  import riscv_pkg::*;

  logic            regwriteE, memwriteE, jumpE, branchE, alusrcE;
  logic [1:0]      resultsrcE;
  logic [2:0]      alucontrolE;
  logic [XLEN-1:0] Rd1E, Rd2E, pcE, ImmextE, pcplus4E;
  logic [4:0]      RdE, Rs1E, Rs2E;
  logic            regwriteW;
  logic [4:0]      RdW;
  logic [XLEN-1:0] resultW;

  logic            pcsrcE;
  logic [XLEN-1:0] pctargetE;
  logic            regwriteM, memwriteM;
  logic [1:0]      resultsrcM;
  logic [XLEN-1:0] aluresultM, writedataM, pcplus4M;
  logic [4:0]      RdM;

  modport master (
    output regwriteE, memwriteE, jumpE, branchE, alusrcE, resultsrcE, alucontrolE,
           Rd1E, Rd2E, pcE, ImmextE, pcplus4E, RdE, Rs1E, Rs2E, regwriteW, RdW, resultW,
    input  pcsrcE, pctargetE, regwriteM, memwriteM, resultsrcM, aluresultM, writedataM,
           pcplus4M, RdM
  );

  modport slave (
    input  regwriteE, memwriteE, jumpE, branchE, alusrcE, resultsrcE, alucontrolE,
           Rd1E, Rd2E, pcE, ImmextE, pcplus4E, RdE, Rs1E, Rs2E, regwriteW, RdW, resultW,
    output pcsrcE, pctargetE, regwriteM, memwriteM, resultsrcM, aluresultM, writedataM,
           pcplus4M, RdM
  );
endinterface

// File: rtl/execute_alu.sv
// Combinational RV32I ALU subset: add, sub, and, or, signed slt; unknown ops give 0.
module alu
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  input  logic [2:0]      alucontrol,
  output logic [XLEN-1:0] result,
  output logic            zero
);
  logic lt;

  assign lt = $signed(srcA) < $signed(srcB);

  always_comb begin
    result = '0;
    case (alucontrol)
      ALU_ADD: result = srcA + srcB;
      ALU_SUB: result = srcA - srcB;
      ALU_AND: result = srcA & srcB;
      ALU_OR:  result = srcA | srcB;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, lt};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);
endmodule

// File: rtl/execute.sv
// Execute stage: operand forwarding, ALU, branch/jump redirect and the EX/MEM register.
module execute
  import riscv_pkg::*;
(
  input logic      clk,
  input logic      rst,
  execute_if.slave bus
);
  logic [1:0]      fwdA, fwdB;
  logic [XLEN-1:0] srcA, fwdBVal, srcB, aluResult;
  logic            zeroE;

  assign fwdA = fwdSel(bus.regwriteM, bus.RdM, bus.regwriteW, bus.RdW, bus.Rs1E);
  assign fwdB = fwdSel(bus.regwriteM, bus.RdM, bus.regwriteW, bus.RdW, bus.Rs2E);

  always_comb begin
    srcA = bus.Rd1E;
    case (fwdA)
      FWD_M:   srcA = bus.aluresultM;
      FWD_W:   srcA = bus.resultW;
      default: srcA = bus.Rd1E;
    endcase
  end

  always_comb begin
    fwdBVal = bus.Rd2E;
    case (fwdB)
      FWD_M:   fwdBVal = bus.aluresultM;
      FWD_W:   fwdBVal = bus.resultW;
      default: fwdBVal = bus.Rd2E;
    endcase
  end

  assign srcB = bus.alusrcE ? bus.ImmextE : fwdBVal;

  alu uAlu (
    .srcA       (srcA),
    .srcB       (srcB),
    .alucontrol (bus.alucontrolE),
    .result     (aluResult),
    .zero       (zeroE)
  );

  // Redirect is resolved in the same cycle; younger instructions are flushed elsewhere.
  assign bus.pctargetE = bus.pcE + bus.ImmextE;
  assign bus.pcsrcE    = bus.jumpE | (bus.branchE & zeroE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.regwriteM  <= 1'b0;
      bus.resultsrcM <= 2'b00;
      bus.memwriteM  <= 1'b0;
      bus.aluresultM <= '0;
      bus.writedataM <= '0;
      bus.RdM        <= 5'd0;
      bus.pcplus4M   <= '0;
    end else begin
      bus.regwriteM  <= bus.regwriteE;
      bus.resultsrcM <= bus.resultsrcE;
      bus.memwriteM  <= bus.memwriteE;
      bus.aluresultM <= aluResult;
      bus.writedataM <= fwdBVal;
      bus.RdM        <= bus.RdE;
      bus.pcplus4M   <= bus.pcplus4E;
    end
  end
endmodule
